sobel_edge_stream: RTL

Streaming 3x3 Sobel edge detector with parametrised pixel width and image size, and internal line buffers (no external FIFO IP). It accepts one grey pixel per pi_flag and emits one result per interior pixel. Threshold and output mode are runtime inputs. Frame markers are supported on both input and output. It sits between the grey-conversion stage and the display/UART output path, and replaces the fixed 100x100, 8-bit, FIFO-based edge stage.

---
 rtl/sobel_pkg.sv | 24 ++
 rtl/sobel_line_buf.sv | 49 ++++
 rtl/sobel_edge_stream.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel edge stage.
// Widths derive from the pixel width so every file agrees on them.
package sobel_pkg;

    localparam int LATENCY = 4;

    localparam logic MODE_BIN = 1'b0;
    localparam logic MODE_MAG = 1'b1;

    // Gradient width: |gx|+|gy| <= 8*(2^dw-1) needs three extra bits.
    function automatic int g_w(input int dw);
        return dw + 3;
    endfunction

    function automatic logic [31:0] white(input int dw);
        return (32'd1 << dw) - 32'd1;
    endfunction

    // All-zero pixel of the same width as white().
    function automatic logic [31:0] black(input int dw);
        return white(dw) & ~white(dw);
    endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two-row line store (rows r-1 and r-2) with circular column pointer.
// Reads are combinational so the window can load in the accept cycle.
module sobel_line_buf
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              i_flag,
    input  logic              i_sof,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_row1,
    output logic [DATA_W-1:0] o_row2
);

    localparam int AW = $clog2(IMG_W);

    logic [DATA_W-1:0] r_mem1 [IMG_W];
    logic [DATA_W-1:0] r_mem2 [IMG_W];
    logic [AW-1:0]     r_ptr;
    logic [AW-1:0]     w_ptr;

    // Start of frame snaps the pointer back to column 0.
    always_comb begin
        w_ptr  = i_sof ? '0 : r_ptr;
        o_row1 = r_mem1[w_ptr];
        o_row2 = r_mem2[w_ptr];
    end

    // Column pointer advances per accepted pixel and wraps at the line end.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_ptr <= '0;
        end else if (i_flag) begin
            r_ptr <= (w_ptr == AW'(IMG_W - 1)) ? '0 : w_ptr + AW'(1);
        end
    end

    // Age row r-1 into r-2 and store the new pixel as row r-1.
    always_ff @(posedge sys_clk) begin
        if (i_flag) begin
            r_mem2[w_ptr] <= r_mem1[w_ptr];
            r_mem1[w_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector, one result per interior pixel.
// Stages: window load, gx/gy, magnitude, output register (4 clocks).
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 100,
    parameter  int IMG_H  = 100,
    localparam int G_W    = g_w(DATA_W)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pi_flag,
    input  logic              pi_sof,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [G_W-1:0]    threshold,
    input  logic              mode,
    output logic              po_flag,
    output logic              po_sof,
    output logic              po_eol,
    output logic [DATA_W-1:0] po_data
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [DATA_W-1:0] BLACK = DATA_W'(black(DATA_W));
    localparam logic [DATA_W-1:0] WHITE = DATA_W'(white(DATA_W));
    localparam logic [G_W-1:0]    SAT   = G_W'(white(DATA_W));

    function automatic logic signed [G_W-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed({3'b000, p});
    endfunction

    logic [CW-1:0]     r_col, w_col;
    logic [RW-1:0]     r_row, w_row;
    logic              w_last_col, w_last_row, w_win;
    logic [DATA_W-1:0] w_row1, w_row2;
    logic [DATA_W-1:0] r_a1, r_a2, r_a3, r_b1, r_b2, r_b3, r_c1, r_c2, r_c3;
    logic              r_v0, r_v1, r_v2;
    logic              r_sof0, r_sof1, r_sof2;
    logic              r_eol0, r_eol1, r_eol2;
    logic signed [G_W-1:0] r_gx, r_gy;
    logic [G_W-1:0]    w_absx, w_absy, r_mag, r_thr;
    logic              r_mode;
    logic [DATA_W-1:0] w_res;

    sobel_line_buf #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_line_buf (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .i_flag    (pi_flag),
        .i_sof     (pi_sof),
        .i_data    (pi_data),
        .o_row1    (w_row1),
        .o_row2    (w_row2)
    );

    // Position of the pixel being accepted; sof forces (0,0).
    always_comb begin
        w_col      = pi_sof ? '0 : r_col;
        w_row      = pi_sof ? '0 : r_row;
        w_last_col = (w_col == CW'(IMG_W - 1));
        w_last_row = (w_row == RW'(IMG_H - 1));
        w_win      = pi_flag && (w_row >= RW'(2)) && (w_col >= CW'(2));
    end

    // Column/row counters wrap on their own, so no sof is needed per frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (pi_flag) begin
            r_col <= w_last_col ? '0 : w_col + CW'(1);
            if (w_last_col) r_row <= w_last_row ? '0 : w_row + RW'(1);
            else            r_row <= w_row;
        end
    end

    // Edge 0: shift the 3x3 window left and tag interior centres.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {r_a1, r_a2, r_a3} <= '0;
            {r_b1, r_b2, r_b3} <= '0;
            {r_c1, r_c2, r_c3} <= '0;
            r_v0   <= 1'b0;
            r_sof0 <= 1'b0;
            r_eol0 <= 1'b0;
        end else begin
            if (pi_flag) begin
                {r_a1, r_a2, r_a3} <= {r_a2, r_a3, w_row2};
                {r_b1, r_b2, r_b3} <= {r_b2, r_b3, w_row1};
                {r_c1, r_c2, r_c3} <= {r_c2, r_c3, pi_data};
            end
            r_v0   <= w_win;
            r_sof0 <= w_win && (w_row == RW'(2)) && (w_col == CW'(2));
            r_eol0 <= w_win && w_last_col;
        end
    end

    // Edge 1: signed gradients, wide enough that nothing truncates.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_gx   <= '0;
            r_gy   <= '0;
            r_v1   <= 1'b0;
            r_sof1 <= 1'b0;
            r_eol1 <= 1'b0;
        end else begin
            if (r_v0) begin
                r_gx <= (ext(r_a3) - ext(r_a1))
                      + ((ext(r_b3) - ext(r_b1)) <<< 1)
                      + (ext(r_c3) - ext(r_c1));
                r_gy <= (ext(r_a1) - ext(r_c1))
                      + ((ext(r_a2) - ext(r_c2)) <<< 1)
                      + (ext(r_a3) - ext(r_c3));
            end
            r_v1   <= r_v0;
            r_sof1 <= r_sof0;
            r_eol1 <= r_eol0;
        end
    end

    // Absolute values; the most negative gradient never reaches -2^(G_W-1).
    always_comb begin
        w_absx = r_gx[G_W-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_absy = r_gy[G_W-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
    end

    // Edge 2: magnitude, with mode and threshold captured alongside it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_mag  <= '0;
            r_thr  <= '0;
            r_mode <= MODE_BIN;
            r_v2   <= 1'b0;
            r_sof2 <= 1'b0;
            r_eol2 <= 1'b0;
        end else begin
            if (r_v1) begin
                r_mag  <= w_absx + w_absy;
                r_thr  <= threshold;
                r_mode <= mode;
            end
            r_v2   <= r_v1;
            r_sof2 <= r_sof1;
            r_eol2 <= r_eol1;
        end
    end

    // Strong edges are drawn black in the binary map; ties stay white.
    always_comb begin
        if (r_mode == MODE_MAG) w_res = (r_mag > SAT) ? WHITE : r_mag[DATA_W-1:0];
        else                    w_res = (r_mag > r_thr) ? BLACK : WHITE;
    end

    // Edge 3: registered outputs; data holds between results.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            po_flag <= 1'b0;
            po_sof  <= 1'b0;
            po_eol  <= 1'b0;
            po_data <= '0;
        end else begin
            po_flag <= r_v2;
            po_sof  <= r_v2 && r_sof2;
            po_eol  <= r_v2 && r_eol2;
            if (r_v2) po_data <= w_res;
        end
    end

endmodule
